// File: rtl/etx_serdes_tx.sv
// Transmit gearbox: splits a PW-bit word into PW/LW lane beats with a frame bit per beat,
// and synchronises and stretches the wr/rd wait pushback inputs.
module etx_serdes_tx #(
    parameter int PW       = 64,
    parameter int LW       = 16,
    parameter int MSBFIRST = 0,
    parameter int INVERT   = 0,
    parameter int HOLD     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PW-1:0]     din,
    input  logic [PW/LW-1:0]  frame_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [LW-1:0]     lane_data,
    output logic              lane_frame,
    input  logic              wr_wait_in,
    input  logic              rd_wait_in,
    output logic              wr_wait,
    output logic              rd_wait
);
    localparam int N  = PW / LW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [HW-1:0] HOLD_VAL = HW'(HOLD);
    localparam logic          INV      = (INVERT != 0);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   sh_reg, sh_next, sh_adv;
    logic [N-1:0]    fr_reg, fr_next;
    logic [LW-1:0]   beat, lane_data_reg, lane_data_next;
    logic            lane_frame_reg, lane_frame_next;
    logic            accept;

    // The current beat always sits at the exit end of the shift register.
    generate
        if (MSBFIRST != 0) begin : g_msb
            assign beat   = sh_reg[PW-1 -: LW];
            assign sh_adv = {sh_reg[PW-LW-1:0], {LW{1'b0}}};
        end else begin : g_lsb
            assign beat   = sh_reg[LW-1:0];
            assign sh_adv = {{LW{1'b0}}, sh_reg[PW-1:LW]};
        end
    endgenerate

    assign ready_out = (state_reg == IDLE) | (cnt_reg == LAST);
    assign accept    = valid_in & ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sh_reg         <= '0;
            fr_reg         <= '0;
            lane_data_reg  <= {LW{INV}};
            lane_frame_reg <= INV;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sh_reg         <= sh_next;
            fr_reg         <= fr_next;
            lane_data_reg  <= lane_data_next;
            lane_frame_reg <= lane_frame_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        sh_next         = sh_reg;
        fr_next         = fr_reg;
        lane_data_next  = {LW{INV}};
        lane_frame_next = INV;
        if (state_reg == SHIFT) begin
            lane_data_next  = beat ^ {LW{INV}};
            lane_frame_next = fr_reg[0] ^ INV;
        end
        // A reload on the last beat lets the next word follow with no idle beat.
        if (accept) begin
            state_next = SHIFT;
            cnt_next   = '0;
            sh_next    = din;
            fr_next    = frame_in;
        end else if (state_reg == SHIFT) begin
            if (cnt_reg == LAST) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt_reg + CW'(1);
                sh_next  = sh_adv;
                fr_next  = {1'b0, fr_reg[N-1:1]};
            end
        end
    end

    assign lane_data  = lane_data_reg;
    assign lane_frame = lane_frame_reg;

    logic [1:0] raw_level;
    logic [1:0] wait_level;

    assign raw_level = {rd_wait_in, wr_wait_in} ^ {2{INV}};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wait
            logic          sync1_reg, sync2_reg;
            logic [HW-1:0] hold_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    hold_reg  <= '0;
                end else begin
                    sync1_reg <= raw_level[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg) begin
                        hold_reg <= HOLD_VAL;
                    end else if (hold_reg != '0) begin
                        hold_reg <= hold_reg - HW'(1);
                    end
                end
            end

            // Stretch keeps a single-cycle glitch visible for HOLD+1 cycles.
            assign wait_level[gi] = sync2_reg | (hold_reg != '0);
        end
    endgenerate

    assign wr_wait = wait_level[0];
    assign rd_wait = wait_level[1];

endmodule

// File: tb/tb_etx_serdes_tx.sv
// Bench for etx_serdes_tx: three configurations checked every cycle against a beat-queue
// model, plus directed literal sequences for the main scenarios.
module tb_etx_serdes_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din [3];
    logic [3:0]  frame_in [3];
    logic        valid_in [3];
    logic        wr_in [3];
    logic        rd_in [3];

    logic        ready0, ready1, ready2;
    logic [15:0] lane0, lane2;
    logic [7:0]  lane1;
    logic        lf0, lf1, lf2;
    logic        wrw0, wrw1, wrw2;
    logic        rdw0, rdw1, rdw2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    etx_serdes_tx #(.PW(64), .LW(16), .MSBFIRST(0), .INVERT(0), .HOLD(4)) u0 (
        .clk(clk), .reset(reset), .din(din[0]), .frame_in(frame_in[0]), .valid_in(valid_in[0]),
        .ready_out(ready0), .lane_data(lane0), .lane_frame(lf0),
        .wr_wait_in(wr_in[0]), .rd_wait_in(rd_in[0]), .wr_wait(wrw0), .rd_wait(rdw0));

    etx_serdes_tx #(.PW(32), .LW(8), .MSBFIRST(1), .INVERT(0), .HOLD(2)) u1 (
        .clk(clk), .reset(reset), .din(din[1][31:0]), .frame_in(frame_in[1]), .valid_in(valid_in[1]),
        .ready_out(ready1), .lane_data(lane1), .lane_frame(lf1),
        .wr_wait_in(wr_in[1]), .rd_wait_in(rd_in[1]), .wr_wait(wrw1), .rd_wait(rdw1));

    etx_serdes_tx #(.PW(64), .LW(16), .MSBFIRST(0), .INVERT(1), .HOLD(3)) u2 (
        .clk(clk), .reset(reset), .din(din[2]), .frame_in(frame_in[2]), .valid_in(valid_in[2]),
        .ready_out(ready2), .lane_data(lane2), .lane_frame(lf2),
        .wr_wait_in(wr_in[2]), .rd_wait_in(rd_in[2]), .wr_wait(wrw2), .rd_wait(rdw2));

    int pw_a   [3] = '{64, 32, 64};
    int lw_a   [3] = '{16, 8, 16};
    int msb_a  [3] = '{0, 1, 0};
    int inv_a  [3] = '{0, 0, 1};
    int hold_a [3] = '{4, 2, 3};

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] t=%0t: got %0h, required %0h", name, inst, $time, act, exp);
        end
    endtask

    // Model: each accepted word becomes N pending beats; one beat leaves per clock edge.
    logic [15:0] bq_d [3][8];
    logic        bq_f [3][8];
    int          bq_n [3];
    logic [15:0] exp_d [3];
    logic        exp_f [3], exp_rdy [3], exp_wr [3], exp_rd [3];
    longint      last_wr [3], last_rd [3];
    longint      edge_no = 0;
    bit          known = 0;
    logic [15:0] act_d [3];
    logic        act_f [3], act_rdy [3], act_wr [3], act_rd [3];
    logic [63:0] lmask, wbeat;
    int          sh;
    bit          acc;
    logic        inv;

    always @(negedge clk) begin
        act_d   = '{lane0, {8'h00, lane1}, lane2};
        act_f   = '{lf0, lf1, lf2};
        act_rdy = '{ready0, ready1, ready2};
        act_wr  = '{wrw0, wrw1, wrw2};
        act_rd  = '{rdw0, rdw1, rdw2};
        if (known) begin
            for (int i = 0; i < 3; i++) begin
                chk("lane_data", i, act_d[i], exp_d[i]);
                chk("lane_frame", i, act_f[i], exp_f[i]);
                chk("ready_out", i, act_rdy[i], exp_rdy[i]);
                chk("wr_wait", i, act_wr[i], exp_wr[i]);
                chk("rd_wait", i, act_rd[i], exp_rd[i]);
            end
        end
        // Advance the model over the coming rising edge using the inputs it will sample.
        for (int i = 0; i < 3; i++) begin
            lmask = (64'd1 << lw_a[i]) - 64'd1;
            inv   = (inv_a[i] != 0);
            if (reset) begin
                bq_n[i]    = 0;
                exp_d[i]   = inv ? lmask[15:0] : 16'h0;
                exp_f[i]   = inv;
                exp_rdy[i] = 1'b1;
                exp_wr[i]  = 1'b0;
                exp_rd[i]  = 1'b0;
                last_wr[i] = -1000;
                last_rd[i] = -1000;
            end else if (known) begin
                acc = valid_in[i] && (bq_n[i] <= 1);
                if (bq_n[i] > 0) begin
                    exp_d[i] = bq_d[i][0] ^ (inv ? lmask[15:0] : 16'h0);
                    exp_f[i] = bq_f[i][0] ^ inv;
                    for (int k = 0; k < 7; k++) begin
                        bq_d[i][k] = bq_d[i][k+1];
                        bq_f[i][k] = bq_f[i][k+1];
                    end
                    bq_n[i]--;
                end else begin
                    exp_d[i] = inv ? lmask[15:0] : 16'h0;
                    exp_f[i] = inv;
                end
                if (acc) begin
                    for (int k = 0; k < pw_a[i] / lw_a[i]; k++) begin
                        sh    = (msb_a[i] != 0) ? pw_a[i] - lw_a[i] * (k + 1) : lw_a[i] * k;
                        wbeat = (din[i] >> sh) & lmask;
                        bq_d[i][bq_n[i]] = wbeat[15:0];
                        bq_f[i][bq_n[i]] = frame_in[i][k];
                        bq_n[i]++;
                    end
                end
                exp_rdy[i] = (bq_n[i] <= 1);
                exp_wr[i]  = ((edge_no + 1 - last_wr[i]) >= 1) && ((edge_no + 1 - last_wr[i]) <= hold_a[i] + 1);
                exp_rd[i]  = ((edge_no + 1 - last_rd[i]) >= 1) && ((edge_no + 1 - last_rd[i]) <= hold_a[i] + 1);
                if (wr_in[i] ^ inv) last_wr[i] = edge_no + 1;
                if (rd_in[i] ^ inv) last_rd[i] = edge_no + 1;
            end
        end
        if (reset) known = 1;
        edge_no++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] tp_u0 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [7:0]  tp_u1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic        tp_f1 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        st_rdy [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    logic [15:0] st_ln  [10] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h0};
    logic        st_lf  [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    logic        r_seen [3];
    int          hi_cnt, first_hi;
    bit          rd_seen;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; frame_in[i] = '0; valid_in[i] = 1'b0;
            wr_in[i] = (i == 2); rd_in[i] = (i == 2);
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("rst_ready", 0, ready0, 1);
        chk("rst_lane", 0, lane0, 16'h0000);
        chk("rst_lane_inv", 2, lane2, 16'hFFFF);
        chk("rst_frame_inv", 2, lf2, 1);
        chk("rst_wait_inv", 2, wrw2, 0);

        // One word into each configuration.
        step();
        valid_in = '{1'b1, 1'b1, 1'b1};
        din[0] = 64'h4444_3333_2222_1111; frame_in[0] = 4'b1111;
        din[1] = 64'h0000_0000_AABB_CCDD; frame_in[1] = 4'b0001;
        din[2] = 64'h0;                   frame_in[2] = 4'b0000;
        step();
        valid_in = '{1'b0, 1'b0, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tp_lsb_beat", 0, lane0, tp_u0[k]);
            chk("tp_lsb_frame", 0, lf0, 1);
            chk("tp_msb_beat", 1, lane1, tp_u1[k]);
            chk("tp_msb_frame", 1, lf1, tp_f1[k]);
            chk("tp_inv_beat", 2, lane2, 16'hFFFF);
            chk("tp_inv_frame", 2, lf2, 1);
        end
        @(negedge clk);
        chk("tp_idle_lane", 0, lane0, 16'h0000);
        chk("tp_idle_frame", 0, lf0, 0);

        // Two words streamed back to back.
        step();
        valid_in[0] = 1'b1; din[0] = 64'h0004_0003_0002_0001; frame_in[0] = 4'b0101;
        step();
        din[0] = 64'h0008_0007_0006_0005; frame_in[0] = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stream_ready", 0, ready0, st_rdy[c]);
            chk("stream_lane", 0, lane0, st_ln[c]);
            chk("stream_frame", 0, lf0, st_lf[c]);
            @(posedge clk);
            #1;
            if (c == 3) valid_in[0] = 1'b0;
        end

        // Single-cycle wr_wait pulse.
        wr_in[0] = 1'b1;
        step();
        wr_in[0] = 1'b0;
        hi_cnt = 0; first_hi = -1; rd_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wrw0) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
            end
            if (rdw0) rd_seen = 1;
        end
        chk("pulse_len", 0, hi_cnt, 5);
        chk("pulse_start", 0, first_hi, 1);
        chk("pulse_rd_quiet", 0, rd_seen, 0);
        chk("held_raw_inv", 2, wrw2, 0);

        // Reset arriving on beat 2.
        step();
        valid_in[0] = 1'b1; din[0] = 64'hDDDD_CCCC_BBBB_AAAA; frame_in[0] = 4'b1111;
        step();
        valid_in[0] = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_lane", 0, lane0, 16'h0000);
        chk("midrst_ready", 0, ready0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_beat", 0, lane0, 16'h0000);
        end

        // Randomized traffic, wait toggling and occasional reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r_seen = '{ready0, ready1, ready2};
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!valid_in[i] || (r_seen[i] && !reset)) begin
                    valid_in[i] = ($urandom_range(0, 3) != 0);
                    din[i]      = {$urandom, $urandom};
                    if (i == 1) din[i][63:32] = '0;
                    frame_in[i] = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 7) == 0) wr_in[i] = ~wr_in[i];
                if ($urandom_range(0, 7) == 0) rd_in[i] = ~rd_in[i];
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        valid_in = '{1'b0, 1'b0, 1'b0};
        repeat (10) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
